// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arb_mux_n selector.
// Selection modes, output state encoding and index wrap.
package arb_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic int unsigned wrap_inc(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Rotate-priority search: first requester at or after ptr.
// Purely combinational; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_IN = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  grant
);

  logic [31:0]      sum;
  logic [SEL_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    sum   = '0;
    idx   = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      sum = 32'(ptr) + 32'(k);
      if (sum >= 32'(NUM_IN))
        sum = sum - 32'(NUM_IN);
      idx = SEL_W'(sum);
      if (req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N:1 registered selector, fixed or round-robin pick.
// Optional ARB_MUX_PERF_EN adds xfer_cnt handshake counter.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef ARB_MUX_PERF_EN
  output logic [31:0]             xfer_cnt,
`endif
  output logic [SEL_W-1:0]        out_src
);

  localparam int NSEL = 1 << SEL_W;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [NSEL-1:0]  valid_ext;
  logic             fix_found;
  logic             rr_found;
  logic [SEL_W-1:0] rr_grant;
  logic             found;
  logic [SEL_W-1:0] grant;
  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] gdata;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr (
    .req   (in_valid),
    .ptr   (ptr),
    .found (rr_found),
    .grant (rr_grant)
  );

  // Out-of-range selects read zero-extended valid bits and never grant.
  assign valid_ext = NSEL'(in_valid);
  assign fix_found = (32'(sel) < NUM_IN) && valid_ext[sel];

  assign found = (mode == MODE_RR) ? rr_found : fix_found;
  assign grant = (mode == MODE_RR) ? rr_grant
               : (fix_found ? sel : '0);

  assign out_valid = (state == ST_FULL);
  assign accept    = (state == ST_EMPTY) || (out_ready && out_valid);
  assign xfer      = accept && found;
  assign in_ready  = xfer ? (NUM_IN'(1) << grant) : '0;
  assign gdata     = in_data[grant*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (accept) begin
      if (found) begin
        state    <= ST_FULL;
        out_data <= gdata;
        out_src  <= grant;
        if (mode == MODE_RR)
          ptr <= SEL_W'(wrap_inc(32'(grant), NUM_IN));
      end else begin
        state <= ST_EMPTY;
      end
    end
  end

`ifdef ARB_MUX_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      xfer_cnt <= '0;
    else if (out_valid && out_ready && (xfer_cnt != 32'hFFFF_FFFF))
      xfer_cnt <= xfer_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n (8-channel and 5-channel builds).
// Directed scenarios plus randomized traffic against a reference model.
module tb_arb_mux_n;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic          mode;
  logic [SW-1:0] sel;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_src;

  logic [5*W-1:0] b_data;
  logic [4:0]    b_valid;
  logic [4:0]    b_ready;
  logic          b_mode;
  logic [2:0]    b_sel;
  logic [W-1:0]  b_out;
  logic          b_ov;
  logic          b_or;
  logic [2:0]    b_src;

`ifdef ARB_MUX_PERF_EN
  logic [31:0]   xfer_cnt;
  logic [31:0]   b_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arb_mux_n #(.WIDTH(W), .NUM_IN(N)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ARB_MUX_PERF_EN
    .xfer_cnt  (xfer_cnt),
`endif
    .out_src   (out_src)
  );

  arb_mux_n #(.WIDTH(W), .NUM_IN(5)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (b_data),
    .in_valid  (b_valid),
    .in_ready  (b_ready),
    .mode      (b_mode),
    .sel       (b_sel),
    .out_data  (b_out),
    .out_valid (b_ov),
    .out_ready (b_or),
`ifdef ARB_MUX_PERF_EN
    .xfer_cnt  (b_cnt),
`endif
    .out_src   (b_src)
  );

  task automatic set_data();
    for (int i = 0; i < N; i++)
      in_data[i*W +: W] = 32'h100 + i;
    for (int i = 0; i < 5; i++)
      b_data[i*W +: W] = 32'h200 + i;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
      bad++;
      $display("FAIL reset_init got v=%b d=%h s=%0d exp 0/0/0",
               out_valid, out_data, out_src);
    end
    rst_n = 1'b1;
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_src !== 3'd2) begin
      bad++;
      $display("FAIL reset_stream got v=%b s=%0d exp 1/2", out_valid, out_src);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
      bad++;
      $display("FAIL reset_async got v=%b d=%h s=%0d exp 0/0/0",
               out_valid, out_data, out_src);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 32'h100) begin
      bad++;
      $display("FAIL reset_first_rr got v=%b s=%0d d=%h exp 1/0/100",
               out_valid, out_src, out_data);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; sel = 3'd3; in_valid = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (in_ready !== 8'h08) begin
        bad++;
        $display("FAIL fixed_ready got %b exp 00001000", in_ready);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h103 || out_src !== 3'd3) begin
        bad++;
        $display("FAIL fixed_data got v=%b d=%h s=%0d exp 1/103/3",
                 out_valid, out_data, out_src);
      end
    end
  endtask

  task automatic test_rr_fair();
    int exp_seq[6] = '{0, 2, 5, 7, 0, 2};
    do_reset();
    mode = 1'b1; in_valid = 8'b1010_0101; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || 32'(out_src) !== exp_seq[k]) begin
        bad++;
        $display("FAIL rr_seq[%0d] got v=%b s=%0d exp 1/%0d",
                 k, out_valid, out_src, exp_seq[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1; in_valid = 8'h10; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (in_ready !== 8'h00 || out_valid !== 1'b1 ||
          out_data !== 32'h104 || out_src !== 3'd4) begin
        bad++;
        $display("FAIL bp_hold[%0d] got r=%b v=%b d=%h s=%0d exp 0/1/104/4",
                 k, in_ready, out_valid, out_data, out_src);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 8'h20) begin
      bad++;
      $display("FAIL bp_release_ready got %b exp 00100000", in_ready);
    end
    @(negedge clk);
    total++;
    if (out_src !== 3'd5 || out_data !== 32'h105) begin
      bad++;
      $display("FAIL bp_next got s=%0d d=%h exp 5/105", out_src, out_data);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    b_mode = 1'b0; b_sel = 3'd7; b_valid = 5'h1F; b_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (b_ready !== 5'h00 || b_ov !== 1'b0) begin
        bad++;
        $display("FAIL bnd_sel7 got r=%b v=%b exp 0/0", b_ready, b_ov);
      end
      @(negedge clk);
    end
    b_mode = 1'b1; b_valid = 5'b01000;
    @(negedge clk);
    b_valid = 5'b10000;
    #1;
    total++;
    if (b_ready !== 5'b10000) begin
      bad++;
      $display("FAIL bnd_rr4_ready got %b exp 10000", b_ready);
    end
    @(negedge clk);
    total++;
    if (b_ov !== 1'b1 || b_src !== 3'd4 || b_out !== 32'h204) begin
      bad++;
      $display("FAIL bnd_rr4 got v=%b s=%0d d=%h exp 1/4/204", b_ov, b_src, b_out);
    end
    b_valid = 5'b10001;
    #1;
    total++;
    if (b_ready !== 5'b00001) begin
      bad++;
      $display("FAIL bnd_wrap_ready got %b exp 00001", b_ready);
    end
    @(negedge clk);
    total++;
    if (b_src !== 3'd0 || b_out !== 32'h200) begin
      bad++;
      $display("FAIL bnd_wrap got s=%0d d=%h exp 0/200", b_src, b_out);
    end
    b_valid = '0;
  endtask

  task automatic test_random();
    bit          mfull = 0;
    int          mptr  = 0;
    logic [W-1:0] mdata = '0;
    int          msrc  = 0;
    int          mcnt  = 0;
    bit          gfound;
    int          g;
    bit          acc;
    logic [N-1:0] exp_ready;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = N'($urandom);
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        in_data[i*W +: W] = $urandom;
      #1;
      gfound = 0; g = 0;
      if (mode == 1'b0) begin
        if (in_valid[sel]) begin gfound = 1; g = int'(sel); end
      end else begin
        for (int k = 0; k < N; k++)
          if (!gfound && in_valid[(mptr + k) % N]) begin
            gfound = 1; g = (mptr + k) % N;
          end
      end
      acc = !mfull || out_ready;
      exp_ready = (acc && gfound) ? (N'(1) << g) : '0;
      total++;
      if (in_ready !== exp_ready) begin
        bad++;
        $display("FAIL rand_ready[%0d] got %b exp %b", cyc, in_ready, exp_ready);
      end
      if (mfull && out_ready) mcnt++;
      if (acc) begin
        if (gfound) begin
          mfull = 1; mdata = in_data[g*W +: W]; msrc = g;
          if (mode) mptr = (g + 1) % N;
        end else begin
          mfull = 0;
        end
      end
      @(negedge clk);
      total++;
      if (out_valid !== mfull || out_data !== mdata || 32'(out_src) !== msrc) begin
        bad++;
        $display("FAIL rand_out[%0d] got v=%b d=%h s=%0d exp %b/%h/%0d",
                 cyc, out_valid, out_data, out_src, mfull, mdata, msrc);
      end
    end
`ifdef ARB_MUX_PERF_EN
    total++;
    if (xfer_cnt !== 32'(mcnt)) begin
      bad++;
      $display("FAIL perf_cnt got %0d exp %0d", xfer_cnt, mcnt);
    end
`endif
  endtask

  initial begin
    in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    b_valid = '0; b_mode = 1'b0; b_sel = '0; b_or = 1'b0;
    set_data();
    test_reset();
    test_fixed();
    test_rr_fair();
    test_backpressure();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
